// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: async serial frame builder for a LSB-first PTS shift register.
// Handles start/data/parity/stop framing and per-bit load/shift strobe timing.
module tx_frame_ctrl #(
    parameter  int DATA_BITS    = 8,
    parameter  int CLKS_PER_BIT = 10,
    parameter  int PARITY_EN    = 0,
    parameter  int PARITY_ODD   = 0,
    localparam int FRAME_BITS   = DATA_BITS + 2 + PARITY_EN
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  tx_valid,
    input  logic [DATA_BITS-1:0]  tx_data,
    output logic                  tx_ready,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  load_enable,
    output logic                  shift_enable,
    output logic                  tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic [FRAME_BITS-1:0]   frame_new;

    // Frame image for the incoming word: stop on top, start at bit 0.
    generate
        if (PARITY_EN != 0) begin : g_par
            logic par;
            assign par = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
            assign frame_new = {1'b1, par, tx_data, 1'b0};
        end else begin : g_nopar
            assign frame_new = {1'b1, tx_data, 1'b0};
        end
    endgenerate

    // State, counters and captured frame; line idles high out of reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
        end
    end

    // Next-state and strobe decode; the stop bit ends one cycle early
    // so that DONE lands on the last cycle the stop bit is on the line.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        frame_d      = frame_q;
        tx_ready     = 1'b0;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        tx_done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    frame_d = frame_new;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_enable = 1'b1;
                cnt_d       = '0;
                bit_d       = '0;
                state_d     = SEND;
            end
            SEND: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    bit_d        = bit_q + BIT_W'(1);
                    shift_enable = (bit_q < BIT_LAST);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (bit_q == BIT_LAST && cnt_q == CNT_STOP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                tx_done = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign frame_out = frame_q;

endmodule
